// File: rtl/ecc_secded_dec_pipe_pkg.sv
// SECDED helpers shared by the read-side decoder and the write-side encoder.
// H columns are generated from the data width, so both sides agree for any width.
package ecc_pkg;
    localparam int ECC_MAX_DW = 247;
    localparam int ECC_MAX_PW = 9;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_SBIT = 2'd1;
    localparam logic [1:0] ERR_DBIT = 2'd2;

    function automatic int ecc_parity_width(input int dw);
        int p;
        p = 1;
        while (((1 << p) - p - 1) < dw) p++;
        return p + 1;
    endfunction

    // Column of data bit i: (i+1)-th non-power-of-two >= 3, top bit forces odd weight.
    function automatic logic [ECC_MAX_PW-1:0] ecc_col(input int i, input int pw);
        logic [ECC_MAX_PW-1:0] col;
        int n;
        int v;
        col = '0;
        n   = 0;
        v   = 3;
        while (n <= i) begin
            if ((v & (v - 1)) != 0) begin
                if (n == i) col = v[ECC_MAX_PW-1:0];
                n++;
            end
            v++;
        end
        if (!(^col)) col = col | (ECC_MAX_PW'(1) << (pw - 1));
        return col;
    endfunction

    function automatic logic [ECC_MAX_PW-1:0] ecc_encode(input logic [ECC_MAX_DW-1:0] d, input int dw);
        logic [ECC_MAX_PW-1:0] p;
        int pw;
        pw = ecc_parity_width(dw);
        p  = '0;
        for (int i = 0; i < dw; i++) begin
            if (d[i]) p = p ^ ecc_col(i, pw);
        end
        return p;
    endfunction
endpackage

// File: rtl/ecc_secded_dec_pipe_if.sv
// Streaming read-path bus into and out of the SECDED decoder.
// master drives words and out_ready; slave is the decoder.
interface ecc_secded_dec_pipe_if
    import ecc_pkg::*;
#(
    parameter int DW = 53,
    parameter int TW = 8
);
    localparam int PW = ecc_parity_width(DW);

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [PW-1:0] in_parity;
    logic [TW-1:0] in_tag;
    logic          in_bypass;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_sbit_err;
    logic          out_dbit_err;

    modport master (
        output in_valid, in_data, in_parity, in_tag, in_bypass, out_ready,
        input  in_ready, out_valid, out_data, out_sbit_err, out_dbit_err
    );

    modport slave (
        input  in_valid, in_data, in_parity, in_tag, in_bypass, out_ready,
        output in_ready, out_valid, out_data, out_sbit_err, out_dbit_err
    );
endinterface

// File: rtl/ecc_secded_dec_pipe_stats.sv
// Saturating single/double error counters plus a first-error log with sticky valid.
// Counts and logs only accepted beats; clears win over increments, new errors win over log_clr.
module ecc_err_stats #(
    parameter int PW        = 7,
    parameter int TW        = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_beat,
    input  logic                 i_sbit,
    input  logic                 i_dbit,
    input  logic [PW-1:0]        i_syndrome,
    input  logic [TW-1:0]        i_tag,
    input  logic                 i_cnt_clr,
    input  logic                 i_log_clr,
    output logic [CNT_WIDTH-1:0] o_sbit_cnt,
    output logic [CNT_WIDTH-1:0] o_dbit_cnt,
    output logic                 o_log_valid,
    output logic [PW-1:0]        o_log_syndrome,
    output logic [TW-1:0]        o_log_tag,
    output logic                 o_log_dbit
);
    logic [CNT_WIDTH-1:0] r_sbit_cnt;
    logic [CNT_WIDTH-1:0] r_dbit_cnt;
    logic                 r_log_vld;
    logic [PW-1:0]        r_log_syn;
    logic [TW-1:0]        r_log_tag;
    logic                 r_log_dbit;
    logic                 w_capture;

    assign w_capture = i_beat && (i_sbit || i_dbit) && (!r_log_vld || i_log_clr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sbit_cnt <= '0;
            r_dbit_cnt <= '0;
        end else if (i_cnt_clr) begin
            r_sbit_cnt <= '0;
            r_dbit_cnt <= '0;
        end else begin
            if (i_beat && i_sbit && (r_sbit_cnt != '1)) r_sbit_cnt <= r_sbit_cnt + CNT_WIDTH'(1);
            if (i_beat && i_dbit && (r_dbit_cnt != '1)) r_dbit_cnt <= r_dbit_cnt + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_log_vld  <= 1'b0;
            r_log_syn  <= '0;
            r_log_tag  <= '0;
            r_log_dbit <= 1'b0;
        end else if (w_capture) begin
            r_log_vld  <= 1'b1;
            r_log_syn  <= i_syndrome;
            r_log_tag  <= i_tag;
            r_log_dbit <= i_dbit;
        end else if (i_log_clr) begin
            r_log_vld  <= 1'b0;
        end
    end

    assign o_sbit_cnt     = r_sbit_cnt;
    assign o_dbit_cnt     = r_dbit_cnt;
    assign o_log_valid    = r_log_vld;
    assign o_log_syndrome = r_log_syn;
    assign o_log_tag      = r_log_tag;
    assign o_log_dbit     = r_log_dbit;
endmodule

// File: rtl/ecc_secded_dec_pipe.sv
// Pipelined SECDED decoder for RAM read paths: fixed 2-cycle latency, 1 word/cycle.
// Global enable: both stages hold while the output is valid and not accepted.
module ecc_secded_dec_pipe
    import ecc_pkg::*;
#(
    parameter  int DATA_WIDTH   = 53,
    parameter  int TAG_WIDTH    = 8,
    parameter  int CNT_WIDTH    = 16,
    localparam int PARITY_WIDTH = ecc_parity_width(DATA_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    ecc_secded_dec_pipe_if.slave    bus,
    output logic [CNT_WIDTH-1:0]    sbit_cnt,
    output logic [CNT_WIDTH-1:0]    dbit_cnt,
    input  logic                    cnt_clr,
    output logic                    log_valid,
    output logic [PARITY_WIDTH-1:0] log_syndrome,
    output logic [TAG_WIDTH-1:0]    log_tag,
    output logic                    log_dbit,
    input  logic                    log_clr,
    output logic                    irq
);
    logic                    w_adv;
    logic [PARITY_WIDTH-1:0] w_col [DATA_WIDTH];
    logic [PARITY_WIDTH-1:0] w_calc;
    logic [DATA_WIDTH-1:0]   w_flip;
    logic [1:0]              w_err;

    logic                    r_s1_vld;
    logic                    r_s1_byp;
    logic [DATA_WIDTH-1:0]   r_s1_data;
    logic [TAG_WIDTH-1:0]    r_s1_tag;
    logic [PARITY_WIDTH-1:0] r_s1_syn;

    logic                    r_o_vld;
    logic                    r_o_sb;
    logic                    r_o_db;
    logic [DATA_WIDTH-1:0]   r_o_data;
    logic [TAG_WIDTH-1:0]    r_o_tag;
    logic [PARITY_WIDTH-1:0] r_o_syn;

    assign w_adv       = !r_o_vld || bus.out_ready;
    assign bus.in_ready = w_adv;

    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_col
        localparam logic [ECC_MAX_PW-1:0] COL = ecc_col(gi, PARITY_WIDTH);
        assign w_col[gi] = COL[PARITY_WIDTH-1:0];
    end

    always_comb begin
        w_calc = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (bus.in_data[i]) w_calc = w_calc ^ w_col[i];
        end
    end

    // Columns are unique and odd-weight, so at most one flip bit can match.
    always_comb begin
        w_flip = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_flip[i] = (r_s1_syn == w_col[i]);
        end
    end

    always_comb begin
        w_err = ERR_NONE;
        if (!r_s1_byp && (r_s1_syn != '0)) begin
            w_err = ((|w_flip) || $onehot(r_s1_syn)) ? ERR_SBIT : ERR_DBIT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_byp  <= 1'b0;
            r_s1_data <= '0;
            r_s1_tag  <= '0;
            r_s1_syn  <= '0;
        end else if (w_adv) begin
            r_s1_vld  <= bus.in_valid;
            r_s1_byp  <= bus.in_bypass;
            r_s1_data <= bus.in_data;
            r_s1_tag  <= bus.in_tag;
            r_s1_syn  <= bus.in_parity ^ w_calc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_o_vld  <= 1'b0;
            r_o_sb   <= 1'b0;
            r_o_db   <= 1'b0;
            r_o_data <= '0;
            r_o_tag  <= '0;
            r_o_syn  <= '0;
        end else if (w_adv) begin
            r_o_vld  <= r_s1_vld;
            r_o_sb   <= (w_err == ERR_SBIT);
            r_o_db   <= (w_err == ERR_DBIT);
            r_o_data <= r_s1_byp ? r_s1_data : (r_s1_data ^ w_flip);
            r_o_tag  <= r_s1_tag;
            r_o_syn  <= r_s1_syn;
        end
    end

    assign bus.out_valid    = r_o_vld;
    assign bus.out_data     = r_o_data;
    assign bus.out_sbit_err = r_o_sb;
    assign bus.out_dbit_err = r_o_db;

    ecc_err_stats #(
        .PW        (PARITY_WIDTH),
        .TW        (TAG_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_stats (
        .clk            (clk),
        .rst            (rst),
        .i_beat         (r_o_vld && bus.out_ready),
        .i_sbit         (r_o_sb),
        .i_dbit         (r_o_db),
        .i_syndrome     (r_o_syn),
        .i_tag          (r_o_tag),
        .i_cnt_clr      (cnt_clr),
        .i_log_clr      (log_clr),
        .o_sbit_cnt     (sbit_cnt),
        .o_dbit_cnt     (dbit_cnt),
        .o_log_valid    (log_valid),
        .o_log_syndrome (log_syndrome),
        .o_log_tag      (log_tag),
        .o_log_dbit     (log_dbit)
    );

    assign irq = log_valid;
endmodule

// File: doc/ecc_secded_dec_pipe.md
Name: ecc_secded_dec_pipe

Overview:
Parametrised, pipelined SECDED (Hamming plus overall parity) decoder for FIFO/RAM read paths. It replaces the fixed 53-bit combinational checker and generates its H-matrix from DATA_WIDTH. It adds a valid/ready streaming interface with a fixed 2-cycle latency, saturating single- and double-error counters, and a first-error log with a sticky interrupt. It sits between the RAM read port and the FIFO output register.

Parameters:
DATA_WIDTH, 53, protected data bits (4..247).
PARITY_WIDTH, derived localparam: P+1, where P is the smallest value with 2^P-P-1 >= DATA_WIDTH (53 gives 7).
TAG_WIDTH, 8, width of the per-word tag (RAM address) captured in the error log.
CNT_WIDTH, 16, width of each saturating error counter.

Ports:
clk  in  1  block clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input word valid
in_ready  out  1  decoder can accept a word
in_data  in  DATA_WIDTH  raw data read from RAM
in_parity  in  PARITY_WIDTH  stored check bits
in_tag  in  TAG_WIDTH  word tag, logged on error
in_bypass  in  1  per-word bypass: data passes through, no flags, no counting
out_valid  out  1  corrected word valid
out_ready  in  1  downstream accepts the word
out_data  out  DATA_WIDTH  corrected data (raw data when bypassed)
out_sbit_err  out  1  correctable error on this word
out_dbit_err  out  1  uncorrectable error on this word
sbit_cnt  out  CNT_WIDTH  saturating count of single-bit errors
dbit_cnt  out  CNT_WIDTH  saturating count of double-bit errors
cnt_clr  in  1  synchronous clear of both counters
log_valid  out  1  sticky flag: error log holds an entry
log_syndrome  out  PARITY_WIDTH  syndrome of the first logged error
log_tag  out  TAG_WIDTH  tag of the first logged error
log_dbit  out  1  logged error was uncorrectable
log_clr  in  1  clears log_valid; re-arms the log
irq  out  1  equals log_valid

Behaviour:
- H-matrix:
  - Data bit i gets the (i+1)-th integer >= 3 that is not a power of two, giving 3, 5, 6, 7, 9, ... in the low P syndrome bits.
  - The top bit is set so that each column has odd weight. For example, d0 is 1000011 and d3 is 0000111.
  - Parity bit j corresponds to the unit vector with bit j set.
  - Computed parity p equals the XOR of the columns of all set data bits.
- Stage 1 (register): latch data, tag and bypass; compute syndrome = in_parity XOR p.
- Stage 2 (register):
  - Syndrome 0 gives no error.
  - A syndrome equal to a data column flips that data bit and sets sbit.
  - A unit-vector syndrome sets sbit with data unchanged.
  - Any other nonzero syndrome sets dbit with data unchanged.
  - Bypass forces both flags to 0 and passes data raw.
- Latency and handshake:
  - Latency is exactly 2 cycles with no stall; throughput is 1 word per cycle.
  - Handshake uses a global pipeline enable: adv = !out_valid || out_ready, and in_ready = adv.
  - When adv is 0, both stages hold and out_* stay stable.
  - A bubble in stage 1 propagates as out_valid = 0.
- Counters:
  - A counter increments by 1 on an accepted output beat (out_valid && out_ready) carrying the matching flag.
  - Counters saturate at all-ones.
  - cnt_clr has priority over an increment in the same cycle; the counter reads 0 on the next cycle.
- Error log:
  - On the first accepted erroneous beat while log_valid = 0, capture syndrome, tag and dbit, and set log_valid.
  - Later errors do not overwrite the log.
  - When log_clr and a new error occur in the same cycle, the new error is captured and log_valid stays 1.
- Reset: all valids, flags, counters and log fields are 0, and in_ready is 1 after reset. Reset mid-stream discards in-flight words with no output beat.
- out_data and the flags are don't-care while out_valid = 0, but are held stable during a stall.

Decomposition:
- Package ecc_pkg holds:
  - function ecc_parity_width(dw);
  - function ecc_col(i, pw), which returns the H column of data bit i;
  - function ecc_encode(d), shared with the write-side encoder;
  - the localparam for the error-type encoding {NONE, SBIT, DBIT}.
- One natural sub-module, ecc_err_stats, holds the counters and the log, so that other ECC users can reuse them.

Test Plan:
- Clean word (DATA_WIDTH = 53): data = 0, parity = 0 -> out_data = 0, both flags 0, out_valid exactly 2 cycles after acceptance, counters unchanged.
- Correctable data error: d = 53'h1 with parity of 0 (single data-bit flip) -> syndrome 1000011, out_data = 0, sbit = 1, sbit_cnt = 1, log_syndrome = 7'h43, log_tag = in_tag, irq = 1.
- Correctable check-bit error: data = 0, parity = 7'h01 -> sbit = 1, out_data = 0; a second error with a different tag leaves log_tag unchanged.
- Double error: d0 and d1 flipped -> syndrome 0000110, dbit = 1, out_data = raw data, dbit_cnt increments. The same word with in_bypass = 1 -> no flags and no count.
- Backpressure: stream 6 words with out_ready toggling 1,0,0,1 -> every word emitted once in order, and outputs stable throughout each stall.
- Saturation and clear (CNT_WIDTH = 2): 5 single errors -> sbit_cnt = 3. cnt_clr together with an error in the same cycle -> 0. log_clr together with an error in the same cycle -> log_valid stays 1 with the new syndrome. Reset mid-stream -> out_valid = 0 next cycle.
